// File: rtl/m_btb.sv
// m_btb -- direct-mapped, tagged branch target buffer with an n-bit saturating
// direction counter per entry.
//
// The IF stage looks up the fetch PC combinationally. The Ex stage writes each
// resolved conditional branch back on the rising clock edge.
//
// Ports:
//   w_clk, w_rst      clock; asynchronous active-high reset
//   w_ce              clock enable; tables and counters hold while low
//   w_lk_en, w_lk_pc  lookup valid (statistics only) and fetch PC
//   w_lk_hit          entry valid and tag matches (0 while w_rst is high)
//   w_lk_taken        hit & counter MSB
//   w_lk_tpc          predicted target {zeros, target, 2'b00}; 0 on a miss
//   w_up_en           a conditional branch resolved this cycle
//   w_up_pc           PC of the resolved branch
//   w_up_tpc          target of the resolved branch
//   w_up_taken        actual branch outcome
//   w_up_mispred      pipeline flushed for this branch (statistics only)
//   r_st_lookups, r_st_hits, r_st_mispred   saturating statistics counters
//
// Update handshake: there is no back-pressure. An update is accepted on every
// rising edge where w_ce & w_up_en is high and w_rst is low; it becomes
// visible to lookups from the following cycle. There is no write-through
// bypass, so a same-cycle lookup of the same index sees the old contents.
//
// Build option: define BTB_STATS_EN to build the three statistics counters.
// Without it the r_st_* ports are tied to 0 and no counter flops exist.

module m_btb #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 14,
  parameter int CTR_W   = 2
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ce,
  input  logic        w_lk_en,
  input  logic [31:0] w_lk_pc,
  output logic        w_lk_hit,
  output logic        w_lk_taken,
  output logic [31:0] w_lk_tpc,
  input  logic        w_up_en,
  input  logic [31:0] w_up_pc,
  input  logic [31:0] w_up_tpc,
  input  logic        w_up_taken,
  input  logic        w_up_mispred,
  output logic [31:0] r_st_lookups,
  output logic [31:0] r_st_hits,
  output logic [31:0] r_st_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int TGT_W = ADDR_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  // Weakly-taken value given to a freshly allocated entry.
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  // Only the valid bits are reset; tag/target/counter are qualified by valid.
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [TGT_W-1:0]   tgt_mem [ENTRIES];
  logic [CTR_W-1:0]   ctr_mem [ENTRIES];

  // Lookup path
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = w_lk_pc[IDX_W+1:2];
  assign lk_tag = w_lk_pc[ADDR_W-1:IDX_W+2];

  // Gating with w_rst forces the outputs low immediately on reset assertion,
  // without depending on the flop reset propagating through the table read.
  assign lk_hit     = ~w_rst & valid[lk_idx] & (tag_mem[lk_idx] == lk_tag);
  assign w_lk_hit   = lk_hit;
  assign w_lk_taken = lk_hit & ctr_mem[lk_idx][CTR_W-1];
  assign w_lk_tpc   = lk_hit ? 32'({tgt_mem[lk_idx], 2'b00}) : 32'd0;

  // Update path
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [TGT_W-1:0] up_tgt;
  logic             up_hit;
  logic             up_fire;

  assign up_idx  = w_up_pc[IDX_W+1:2];
  assign up_tag  = w_up_pc[ADDR_W-1:IDX_W+2];
  assign up_tgt  = w_up_tpc[ADDR_W-1:2];
  assign up_hit  = valid[up_idx] & (tag_mem[up_idx] == up_tag);
  assign up_fire = w_ce & w_up_en;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      valid <= '0;
    end else if (up_fire & ~up_hit & w_up_taken) begin
      valid[up_idx] <= 1'b1;
    end
  end

  // Table contents carry no reset. The ~w_rst term drops an update that
  // lands on the same edge as a reset, keeping it consistent with valid.
  always_ff @(posedge w_clk) begin
    if (up_fire & ~w_rst) begin
      if (up_hit) begin
        if (w_up_taken) begin
          if (ctr_mem[up_idx] != CTR_MAX) ctr_mem[up_idx] <= ctr_mem[up_idx] + CTR_W'(1);
          tgt_mem[up_idx] <= up_tgt;
        end else if (ctr_mem[up_idx] != '0) begin
          ctr_mem[up_idx] <= ctr_mem[up_idx] - CTR_W'(1);
        end
      end else if (w_up_taken) begin
        // Allocate; any aliasing entry at this index is replaced.
        tag_mem[up_idx] <= up_tag;
        tgt_mem[up_idx] <= up_tgt;
        ctr_mem[up_idx] <= CTR_WEAK;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_st_lookups <= '0;
      r_st_hits    <= '0;
      r_st_mispred <= '0;
    end else if (w_ce) begin
      if (w_lk_en && r_st_lookups != '1) r_st_lookups <= r_st_lookups + 32'd1;
      if (w_lk_en && lk_hit && r_st_hits != '1) r_st_hits <= r_st_hits + 32'd1;
      if (w_up_en && w_up_mispred && r_st_mispred != '1) r_st_mispred <= r_st_mispred + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{w_lk_pc[31:ADDR_W], w_lk_pc[1:0], w_up_pc[31:ADDR_W],
                         w_up_pc[1:0], w_up_tpc[31:ADDR_W], w_up_tpc[1:0]};
`else
  assign r_st_lookups = '0;
  assign r_st_hits    = '0;
  assign r_st_mispred = '0;

  logic unused_bits;
  assign unused_bits = ^{w_lk_en, w_up_mispred, w_lk_pc[31:ADDR_W], w_lk_pc[1:0],
                         w_up_pc[31:ADDR_W], w_up_pc[1:0], w_up_tpc[31:ADDR_W],
                         w_up_tpc[1:0]};
`endif

endmodule

// File: tb/tb_m_btb.sv
// tb_m_btb -- directed scenarios plus randomized traffic for m_btb, checked
// against an array-based reference model of the buffer's rules.

module tb_m_btb;

  localparam int ENTRIES = 64;
  localparam int ADDR_W  = 14;
  localparam int CTR_W   = 2;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_W   = ADDR_W - 2 - IDX_W;
  localparam int CTR_TOP = (1 << CTR_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ce, lk_en, up_en, up_taken, up_mispred;
  logic [31:0] lk_pc, up_pc, up_tpc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_tpc, st_lookups, st_hits, st_mispred;

  m_btb #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W)) dut (
    .w_clk(clk), .w_rst(rst), .w_ce(ce),
    .w_lk_en(lk_en), .w_lk_pc(lk_pc),
    .w_lk_hit(lk_hit), .w_lk_taken(lk_taken), .w_lk_tpc(lk_tpc),
    .w_up_en(up_en), .w_up_pc(up_pc), .w_up_tpc(up_tpc),
    .w_up_taken(up_taken), .w_up_mispred(up_mispred),
    .r_st_lookups(st_lookups), .r_st_hits(st_hits), .r_st_mispred(st_mispred)
  );

  // ---------------- reference model ----------------
  bit     m_valid [ENTRIES];
  int     m_tag   [ENTRIES];
  int     m_tgt   [ENTRIES];
  int     m_ctr   [ENTRIES];
  longint m_lookups, m_hits, m_mispred;

  function automatic int f_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int f_tag(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
  endfunction

  function automatic bit f_hit(input logic [31:0] pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    m_lookups = 0; m_hits = 0; m_mispred = 0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic [31:0] tpc,
                                       input bit taken);
    int i;
    i = f_idx(pc);
    if (f_hit(pc)) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[i] + 1;
        m_tgt[i] = int'((tpc >> 2) % (1 << (ADDR_W - 2)));
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1;
      m_tag[i]   = f_tag(pc);
      m_tgt[i]   = int'((tpc >> 2) % (1 << (ADDR_W - 2)));
      m_ctr[i]   = 1 << (CTR_W - 1);
    end
  endfunction

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hffffffff) ? 32'hffffffff : 32'(v);
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_lookup(input logic [31:0] pc);
    bit h;
    h = f_hit(pc);
    exp_q.push_back({31'd0, h});
    exp_q.push_back({31'd0, h && (m_ctr[f_idx(pc)] >= (1 << (CTR_W - 1)))});
    exp_q.push_back(h ? 32'(m_tgt[f_idx(pc)] << 2) : 32'd0);
    check("lk_hit",   {31'd0, lk_hit},   exp_q.pop_front());
    check("lk_taken", {31'd0, lk_taken}, exp_q.pop_front());
    check("lk_tpc",   lk_tpc,            exp_q.pop_front());
  endtask

  task automatic check_stats();
`ifdef BTB_STATS_EN
    check("st_lookups", st_lookups, sat32(m_lookups));
    check("st_hits",    st_hits,    sat32(m_hits));
    check("st_mispred", st_mispred, sat32(m_mispred));
`else
    check("st_lookups", st_lookups, 32'd0);
    check("st_hits",    st_hits,    32'd0);
    check("st_mispred", st_mispred, 32'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One full cycle: drive at negedge, check lookup before the edge, advance
  // the model at the edge, check statistics after it.
  task automatic cycle(input logic c, input logic le, input logic [31:0] lpc,
                       input logic ue, input logic [31:0] upc, input logic [31:0] utpc,
                       input logic ut, input logic um);
    bit h;
    @(negedge clk);
    ce = c; lk_en = le; lk_pc = lpc;
    up_en = ue; up_pc = upc; up_tpc = utpc; up_taken = ut; up_mispred = um;
    #1;
    check_lookup(lpc);
    h = f_hit(lpc);
    @(posedge clk);
    if (c) begin
      m_lookups += le;
      m_hits    += (le && h);
      m_mispred += (ue && um);
      if (ue) model_update(upc, utpc, ut);
    end
    #1;
    check_stats();
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(1'b1, 1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tpc, input logic t,
                     input logic [31:0] lpc);
    cycle(1'b1, 1'b0, lpc, 1'b1, pc, tpc, t, 1'b0);
  endtask

  // Reset asserted mid-cycle while a hit is presented, held across an edge
  // that carries a taken update which must be discarded.
  task automatic reset_mid(input logic [31:0] pc);
    @(negedge clk);
    ce = 1; lk_en = 1; lk_pc = pc;
    up_en = 1; up_pc = 32'h80; up_tpc = 32'h44; up_taken = 1; up_mispred = 1;
    #1;
    check_lookup(pc);
    #1 rst = 1'b1;
    #1;
    check("rst_hit",   {31'd0, lk_hit},   32'd0);
    check("rst_taken", {31'd0, lk_taken}, 32'd0);
    check("rst_tpc",   lk_tpc,            32'd0);
    model_reset();
    check_stats();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0; up_en = 0; lk_en = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; ce = 0; lk_en = 0; lk_pc = 32'h40;
    up_en = 0; up_pc = 0; up_tpc = 0; up_taken = 0; up_mispred = 0;
    model_reset();
    #2;
    check("reset_hit",   {31'd0, lk_hit},   32'd0);
    check("reset_taken", {31'd0, lk_taken}, 32'd0);
    check("reset_tpc",   lk_tpc,            32'd0);
    check_stats();
    @(negedge clk);
    rst = 1'b0;

    look(32'h40);                                   // empty: miss
    upd(32'h40, 32'h10, 1'b1, 32'h40);              // allocate, ctr=2
    look(32'h40);                                   // hit, taken, tpc 0x10
    for (int i = 0; i < 3; i++) upd(32'h40, 32'h0, 1'b0, 32'h40);  // ctr 1,0,0
    for (int i = 0; i < 4; i++) upd(32'h40, 32'h10, 1'b1, 32'h40); // ctr 1,2,3,3
    for (int i = 0; i < 2; i++) upd(32'h40, 32'h0, 1'b0, 32'h40);  // ctr 2,1
    look(32'h40);

    upd(32'h140, 32'h20, 1'b1, 32'h140);            // alias replaces idx 16
    look(32'h140);
    look(32'h40);
    upd(32'h80, 32'h30, 1'b0, 32'h80);              // not-taken miss: no alloc
    look(32'h80);

    upd(32'h40, 32'h10, 1'b1, 32'h40);              // reclaim idx 16 for 0x40
    upd(32'h40, 32'h30, 1'b1, 32'h40);              // same-cycle: old target seen
    look(32'h40);                                   // new target now

    // Clock enable low: lookups track, nothing updates.
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 32'h3c, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 32'h3c, 1'b1, 1'b1);
    look(32'h200);

    // Statistics scenario: 5 lookups (2 hits) and one mispredicted update.
    look(32'h40); look(32'h40); look(32'h80); look(32'h84); look(32'h300);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h88, 32'h0, 1'b0, 1'b1);

    reset_mid(32'h40);
    look(32'h80);                                   // update at reset edge dropped
    look(32'h40);                                   // valid cleared

    // Randomized traffic over a small set of aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b, t;
      a = (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 2)) << 8) |
          (32'($urandom_range(0, 1)) << 20) | 32'($urandom_range(0, 3));
      b = (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 2)) << 8) |
          (32'($urandom_range(0, 1)) << 24);
      t = $urandom;
      cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), a,
            1'($urandom_range(0, 1)), b, t, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
